// File: rtl/pipeline_pkg.sv
// Shared pipeline constants and the IF/ID register payload type.
// Struct field widths track the default fetch_stage WIDTH/INSTRUCTIONWIDTH.
package pipeline_pkg;

   localparam int unsigned XLEN       = 8;
   localparam int unsigned ILEN       = 24;
   localparam int unsigned PC_STEP    = 4;
   localparam int unsigned R15_OFFSET = 8;  // R15 reads as the current PC plus this

   localparam logic [ILEN-1:0] NOP_INSTR = '0;

   typedef struct packed {
      logic [ILEN-1:0] instr;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pcPlus8;
      logic            valid;
   } if_id_t;

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register: reset zeroes everything, clear injects a bubble
// (instr/valid only, PC fields hold), enable loads a new entry.
module if_id_register
   import pipeline_pkg::*;
#(
   parameter logic [ILEN-1:0] NOPINSTR = NOP_INSTR
) (
   input  logic   clock,
   input  logic   reset,
   input  logic   enable,
   input  logic   clear,
   input  if_id_t d,
   output if_id_t q
);

   always_ff @(posedge clock) begin
      if (reset) begin
         q.instr   <= NOPINSTR;
         q.pc      <= '0;
         q.pcPlus8 <= '0;
         q.valid   <= 1'b0;
      end else if (clear) begin
         q.instr <= NOPINSTR;
         q.valid <= 1'b0;
      end else if (enable) begin
         q <= d;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID register: PC, stall hold, branch redirect/squash.
// Define FETCH_PERF_CNT_EN to add saturating fetchCount/bubbleCount outputs.
module fetch_stage
   import pipeline_pkg::*;
#(
   parameter int unsigned                  WIDTH            = XLEN,
   parameter int unsigned                  INSTRUCTIONWIDTH = ILEN,
   parameter int unsigned                  PCSTEP           = PC_STEP,
   parameter logic [WIDTH-1:0]             RESETPC          = '0,
   parameter logic [INSTRUCTIONWIDTH-1:0]  NOPINSTR         = NOP_INSTR
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        stall,
   input  logic                        branchTaken,
   input  logic [WIDTH-1:0]            branchTarget,
   input  logic [INSTRUCTIONWIDTH-1:0] imemInstruction,
   output logic [WIDTH-1:0]            imemAddress,
   output logic [INSTRUCTIONWIDTH-1:0] instructionD,
   output logic [WIDTH-1:0]            pcD,
   output logic [WIDTH-1:0]            PCPlus8D,
   output logic                        validD
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [15:0]                 fetchCount,
   output logic [15:0]                 bubbleCount
`endif
);

   localparam logic [WIDTH-1:0] PC_INC  = WIDTH'(PCSTEP);
   localparam logic [WIDTH-1:0] R15_INC = WIDTH'(R15_OFFSET);

   logic [WIDTH-1:0] pcF;
   logic [WIDTH-1:0] pc_next;
   if_id_t           if_id_d;
   if_id_t           if_id_q;

   // Redirect beats stall; PC arithmetic wraps modulo 2^WIDTH.
   always_comb begin
      pc_next = pcF;
      if (branchTaken) begin
         pc_next = branchTarget;
      end else if (!stall) begin
         pc_next = pcF + PC_INC;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pcF <= RESETPC;
      end else begin
         pcF <= pc_next;
      end
   end

   always_comb begin
      if_id_d.instr   = imemInstruction;
      if_id_d.pc      = pcF;
      if_id_d.pcPlus8 = pcF + R15_INC;
      if_id_d.valid   = 1'b1;
   end

   if_id_register #(
      .NOPINSTR (NOPINSTR)
   ) u_if_id (
      .clock  (clock),
      .reset  (reset),
      .enable (!stall || branchTaken),
      .clear  (reset || branchTaken),
      .d      (if_id_d),
      .q      (if_id_q)
   );

   assign imemAddress  = pcF;
   assign instructionD = if_id_q.instr;
   assign pcD          = if_id_q.pc;
   assign PCPlus8D     = if_id_q.pcPlus8;
   assign validD       = if_id_q.valid;

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clock) begin
      if (reset) begin
         fetchCount  <= '0;
         bubbleCount <= '0;
      end else if (branchTaken || stall) begin
         if (bubbleCount != 16'hFFFF) bubbleCount <= bubbleCount + 16'd1;
      end else begin
         if (fetchCount != 16'hFFFF) fetchCount <= fetchCount + 16'd1;
      end
   end
`endif

endmodule
